// File: rtl/dft_pkg.sv
// Shared definitions for the 8-point DFT/IDFT datapath: sizes, FSM states,
// the complex sample type and the Q1.14 twiddle table.
package dft_pkg;

  localparam int N      = 8;
  localparam int LOG2N  = 3;
  localparam int Q_FRAC = 14;
  localparam int TW_W   = 16;

  typedef enum logic [1:0] {LOAD, MAC, EMIT} state_t;

  typedef struct packed {
    logic signed [TW_W-1:0] re;
    logic signed [TW_W-1:0] im;
  } complex_t;

  localparam logic signed [TW_W-1:0] TW_COS [N] = '{
    16'sd16384, 16'sd11585, 16'sd0, -16'sd11585,
    -16'sd16384, -16'sd11585, 16'sd0, 16'sd11585
  };

  // sin(2*pi*m/8) is cos shifted by a quarter turn, so one table serves both.
  function automatic complex_t twiddle(input logic [LOG2N-1:0] m);
    complex_t t;
    t.re = TW_COS[m];
    t.im = TW_COS[m + LOG2N'(6)];
    return t;
  endfunction

endpackage

// File: rtl/cmac_q14.sv
// Complex multiply-accumulate against a Q1.14 twiddle, with the rounded and
// saturated scaled output of the accumulator.
module cmac_q14
  import dft_pkg::*;
#(
  parameter int W_IN  = 16,
  parameter int W_TW  = 16,
  parameter int W_ACC = 40,
  parameter int W_OUT = 16,
  parameter int SHIFT = LOG2N + Q_FRAC
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [W_IN-1:0]  x_re,
  input  logic signed [W_IN-1:0]  x_im,
  input  logic signed [W_TW-1:0]  tw_re,
  input  logic signed [W_TW-1:0]  tw_im,
  output logic signed [W_OUT-1:0] y_re,
  output logic signed [W_OUT-1:0] y_im
);

  localparam logic signed [W_ACC-1:0] RND  = W_ACC'(1) <<< (SHIFT - 1);
  localparam logic signed [W_ACC-1:0] OMAX = (W_ACC'(1) <<< (W_OUT - 1)) - W_ACC'(1);
  localparam logic signed [W_ACC-1:0] OMIN = ~OMAX;

  logic signed [W_IN+W_TW-1:0] p_rc, p_is, p_rs, p_ic;
  logic signed [W_ACC-1:0]     acc_re, acc_im;

  assign p_rc = x_re * tw_re;
  assign p_is = x_im * tw_im;
  assign p_rs = x_re * tw_im;
  assign p_ic = x_im * tw_re;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_re <= '0;
      acc_im <= '0;
    end else if (clr) begin
      acc_re <= '0;
      acc_im <= '0;
    end else if (en) begin
      acc_re <= acc_re + W_ACC'(p_rc) - W_ACC'(p_is);
      acc_im <= acc_im + W_ACC'(p_rs) + W_ACC'(p_ic);
    end
  end

  // Drops the Q1.14 fraction and the 1/8 scale together, rounding half up.
  function automatic logic signed [W_OUT-1:0] round_sat(input logic signed [W_ACC-1:0] acc);
    logic signed [W_ACC-1:0] r;
    r = (acc + RND) >>> SHIFT;
    if (r > OMAX) return OMAX[W_OUT-1:0];
    if (r < OMIN) return OMIN[W_OUT-1:0];
    return r[W_OUT-1:0];
  endfunction

  assign y_re = round_sat(acc_re);
  assign y_im = round_sat(acc_im);

endmodule

// File: rtl/idft8_seq.sv
// Sequential 8-point inverse DFT: buffers one frame of bins, then computes each
// output sample with eight MAC cycles and streams it out with backpressure.
module idft8_seq
  import dft_pkg::*;
#(
  parameter int W_IN  = 16,
  parameter int W_OUT = 16,
  parameter int W_TW  = 16,
  parameter int W_ACC = 40
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [W_IN-1:0]  in_re,
  input  logic signed [W_IN-1:0]  in_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [W_OUT-1:0] out_re,
  output logic signed [W_OUT-1:0] out_im,
  output logic                    out_last,
  output logic                    busy
);

  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  state_t                 state;
  logic [LOG2N-1:0]       k, n, m;
  logic signed [W_IN-1:0] bin_re [N];
  logic signed [W_IN-1:0] bin_im [N];
  complex_t               tw;
  logic                   in_fire, out_fire, mac_clr, mac_en;
  logic signed [W_OUT-1:0] y_re, y_im;

  assign in_fire  = (state == LOAD) && in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign m        = k * n;
  assign tw       = twiddle(m);
  assign mac_en   = (state == MAC);
  // Accumulators sit at zero while loading and once the sample has been latched.
  assign mac_clr  = (state == LOAD) || ((state == EMIT) && out_valid);

  // NOTE: the bin buffer carries no reset; every entry is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      bin_re[k] <= in_re;
      bin_im[k] <= in_im;
    end
  end

  cmac_q14 #(
    .W_IN  (W_IN),
    .W_TW  (W_TW),
    .W_ACC (W_ACC),
    .W_OUT (W_OUT)
  ) u_cmac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (mac_clr),
    .en    (mac_en),
    .x_re  (bin_re[k]),
    .x_im  (bin_im[k]),
    .tw_re (tw.re),
    .tw_im (tw.im),
    .y_re  (y_re),
    .y_im  (y_im)
  );

  // NOTE: all FSM state and outputs use non-blocking assignments so every
  // register samples the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      k         <= '0;
      n         <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          in_ready <= 1'b1;
          if (in_fire) begin
            k <= k + 1'b1;
            if (k == LAST) begin
              state    <= MAC;
              in_ready <= 1'b0;
              busy     <= 1'b1;
              k        <= '0;
              n        <= '0;
            end
          end
        end
        MAC: begin
          k <= k + 1'b1;
          if (k == LAST) state <= EMIT;
        end
        EMIT: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_re    <= y_re;
            out_im    <= y_im;
            out_last  <= (n == LAST);
          end else if (out_fire) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (n == LAST) begin
              state    <= LOAD;
              in_ready <= 1'b1;
              busy     <= 1'b0;
            end else begin
              n     <= n + 1'b1;
              state <= MAC;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
